// File: rtl/ysyx_22040237_lsu_pkg.sv
// Shared encodings and the alignment rule for the load/store unit.
package ysyx_22040237_lsu_pkg;

  localparam logic [1:0] MEM_OP_NONE  = 2'b00;
  localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
  localparam logic [1:0] MEM_OP_STORE = 2'b10;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  // An access is aligned when its byte offset is a multiple of its size.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return off[0];
      SIZE_W:  return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22040237_lsu_align.sv
// Byte-lane steering: store mask/data placement, load extraction/extension,
// and the misalignment check for a given doubleword offset and access size.
module ysyx_22040237_lsu_align (
  input  logic [2:0]  addr,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic [7:0]  wmask,
  output logic [63:0] wdata_sh,
  output logic [63:0] ldata,
  output logic        misalign
);
  import ysyx_22040237_lsu_pkg::*;

  logic [5:0]  sh_amt;
  logic [63:0] rsh;
  logic [7:0]  base_mask;

  assign sh_amt   = {addr, 3'b000};
  assign rsh      = rdata >> sh_amt;
  assign wdata_sh = wdata << sh_amt;
  assign wmask    = base_mask << addr;
  assign misalign = misaligned(size, addr);

  // Lane mask for the access size and right-aligned, extended load value.
  always_comb begin
    base_mask = 8'h01;
    ldata     = '0;
    case (size)
      SIZE_B: begin
        base_mask = 8'h01;
        ldata     = {{56{sgn & rsh[7]}}, rsh[7:0]};
      end
      SIZE_H: begin
        base_mask = 8'h03;
        ldata     = {{48{sgn & rsh[15]}}, rsh[15:0]};
      end
      SIZE_W: begin
        base_mask = 8'h0F;
        ldata     = {{32{sgn & rsh[31]}}, rsh[31:0]};
      end
      default: begin
        base_mask = 8'hFF;
        ldata     = rsh;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_22040237_lsu.sv
// Load/store unit: captures one execute beat, issues at most one memory
// request, and presents a single registered writeback beat.
module ysyx_22040237_lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [1:0]  ex_mem_op,
  input  logic [1:0]  ex_size,
  input  logic        ex_signed,
  input  logic [63:0] ex_result,
  input  logic [63:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_wen,
  output logic [63:0] mem_req_addr,
  output logic [63:0] mem_req_wdata,
  output logic [7:0]  mem_req_wmask,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rsp_rdata,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic        wb_wen,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic        wb_misalign
);
  import ysyx_22040237_lsu_pkg::*;

  lsu_state_e  state_q, state_d;

  logic [63:0] req_addr_q,  req_addr_d;
  logic [63:0] req_wdata_q, req_wdata_d;
  logic [7:0]  req_wmask_q, req_wmask_d;
  logic        req_wen_q,   req_wen_d;
  logic [2:0]  off_q,       off_d;
  logic [1:0]  size_q,      size_d;
  logic        sgn_q,       sgn_d;
  logic [4:0]  rd_q,        rd_d;
  logic        wb_wen_q,    wb_wen_d;
  logic [63:0] wb_data_q,   wb_data_d;
  logic        wb_mis_q,    wb_mis_d;

  logic        ex_ld, ex_st;
  logic [2:0]  al_addr;
  logic [1:0]  al_size;
  logic        al_sgn;
  logic [7:0]  al_wmask;
  logic [63:0] al_wdata;
  logic [63:0] al_ldata;
  logic        al_mis;

  assign ex_ld = (ex_mem_op == MEM_OP_LOAD);
  assign ex_st = (ex_mem_op == MEM_OP_STORE);

  // The aligner looks at the incoming beat while idle (for capture) and at
  // the captured beat otherwise (for load extraction), so every output stays
  // registered.
  assign al_addr = (state_q == IDLE) ? ex_result[2:0] : off_q;
  assign al_size = (state_q == IDLE) ? ex_size        : size_q;
  assign al_sgn  = (state_q == IDLE) ? ex_signed      : sgn_q;

  ysyx_22040237_lsu_align u_align (
    .addr     (al_addr),
    .size     (al_size),
    .sgn      (al_sgn),
    .wdata    (ex_wdata),
    .rdata    (mem_rsp_rdata),
    .wmask    (al_wmask),
    .wdata_sh (al_wdata),
    .ldata    (al_ldata),
    .misalign (al_mis)
  );

  // State register; reset drops any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: misaligned and non-memory beats skip straight to writeback.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (ex_valid) state_d = ((ex_ld || ex_st) && !al_mis) ? REQ : DONE;
      REQ:  if (mem_req_ready) state_d = WAIT;
      WAIT: if (mem_rsp_valid) state_d = DONE;
      DONE: if (wb_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    ex_ready      = (state_q == IDLE);
    mem_req_valid = (state_q == REQ);
    wb_valid      = (state_q == DONE);
  end

  // Capture on accept; fill writeback from the response in WAIT.
  always_comb begin
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_wmask_d = req_wmask_q;
    req_wen_d   = req_wen_q;
    off_d       = off_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    rd_d        = rd_q;
    wb_wen_d    = wb_wen_q;
    wb_data_d   = wb_data_q;
    wb_mis_d    = wb_mis_q;
    case (state_q)
      IDLE: if (ex_valid) begin
        req_addr_d  = {ex_result[63:3], 3'b000};
        req_wdata_d = al_wdata;
        req_wmask_d = al_wmask;
        req_wen_d   = ex_st;
        off_d       = ex_result[2:0];
        size_d      = ex_size;
        sgn_d       = ex_signed;
        rd_d        = ex_rd;
        wb_wen_d    = 1'b0;
        wb_data_d   = '0;
        wb_mis_d    = 1'b0;
        if (!(ex_ld || ex_st)) begin
          wb_data_d = ex_result;
          wb_wen_d  = |ex_rd;
        end else if (al_mis) begin
          wb_data_d = ex_result;
          wb_mis_d  = 1'b1;
        end
      end
      WAIT: if (mem_rsp_valid) begin
        wb_data_d = req_wen_q ? '0 : al_ldata;
        wb_wen_d  = !req_wen_q && (|rd_q);
      end
      default: ;
    endcase
  end

  // Capture and writeback registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wmask_q <= '0;
      req_wen_q   <= 1'b0;
      off_q       <= '0;
      size_q      <= '0;
      sgn_q       <= 1'b0;
      rd_q        <= '0;
      wb_wen_q    <= 1'b0;
      wb_data_q   <= '0;
      wb_mis_q    <= 1'b0;
    end else begin
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wmask_q <= req_wmask_d;
      req_wen_q   <= req_wen_d;
      off_q       <= off_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      rd_q        <= rd_d;
      wb_wen_q    <= wb_wen_d;
      wb_data_q   <= wb_data_d;
      wb_mis_q    <= wb_mis_d;
    end
  end

  assign mem_req_wen   = req_wen_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_wdata = req_wdata_q;
  assign mem_req_wmask = req_wmask_q;
  assign wb_wen        = wb_wen_q;
  assign wb_rd         = rd_q;
  assign wb_data       = wb_data_q;
  assign wb_misalign   = wb_mis_q;

endmodule

// File: tb/tb_ysyx_22040237_lsu.sv
// Directed bench for the LSU: a spec-level model predicts each beat, a
// negedge monitor compares every meaningful cycle, and literal checks pin
// the model on the hand-worked cases.
module tb_ysyx_22040237_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [1:0]  ex_mem_op = '0;
  logic [1:0]  ex_size = '0;
  logic        ex_signed = 1'b0;
  logic [63:0] ex_result = '0;
  logic [63:0] ex_wdata = '0;
  logic [4:0]  ex_rd = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_req_wen;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_rsp_valid = 1'b0;
  logic [63:0] mem_rsp_rdata = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic        wb_wen;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        wb_misalign;

  always #5 clk = ~clk;

  ysyx_22040237_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_mem_op(ex_mem_op),
    .ex_size(ex_size), .ex_signed(ex_signed), .ex_result(ex_result),
    .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_wen(wb_wen),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_misalign(wb_misalign)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Expected beat, published by the driver for the monitor.
  logic        exp_active = 1'b0;
  logic        exp_req_on = 1'b0;
  logic [63:0] exp_addr, exp_wdata, exp_wb_data;
  logic [7:0]  exp_wmask;
  logic        exp_wen, exp_wb_wen, exp_wb_mis;
  logic [4:0]  exp_wb_rd;

  // Observations from the last transaction, for literal pins.
  logic [63:0] obs_wb_data, obs_addr, obs_wdata;
  logic [7:0]  obs_wmask;
  logic        obs_wb_wen, obs_mis, obs_req_wen;
  int          obs_lat, obs_reqs;

  // Behavioural model: operates on byte counts and arithmetic masks.
  function automatic void model(input logic [1:0] op, input logic [1:0] size, input logic sgn,
                                input logic [63:0] res, input logic [63:0] rdata, input logic [4:0] rd,
                                output logic mem, output logic mis, output logic wen,
                                output logic [63:0] data);
    int nb, off;
    logic [63:0] m, v;
    nb  = 1 << size;
    off = int'(res[2:0]);
    m   = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
    mem = 1'b0; mis = 1'b0; wen = 1'b0; data = res;
    if (op == 2'b01 || op == 2'b10) begin
      if (off % nb != 0) mis = 1'b1;
      else begin
        mem = 1'b1;
        if (op == 2'b01) begin
          v = (rdata >> (8 * off)) & m;
          if (sgn && nb < 8 && v[8 * nb - 1]) v = v | ~m;
          data = v;
          wen  = (rd != 0);
        end else data = '0;
      end
    end else wen = (rd != 0);
  endfunction

  // Monitor: every cycle while a beat is in flight.
  always @(negedge clk) begin
    if (rst_n && exp_active) begin
      if (mem_req_valid || wb_valid) chk("busy_ex_ready", 64'(ex_ready), 64'd0);
      if (!exp_req_on) chk("no_req", 64'(mem_req_valid), 64'd0);
      else if (mem_req_valid) begin
        chk("req_addr",  mem_req_addr, exp_addr);
        chk("req_wen",   64'(mem_req_wen), 64'(exp_wen));
        chk("req_wdata", mem_req_wdata, exp_wdata);
        chk("req_wmask", 64'(mem_req_wmask), 64'(exp_wmask));
      end
      if (wb_valid) begin
        chk("wb_wen",  64'(wb_wen), 64'(exp_wb_wen));
        chk("wb_rd",   64'(wb_rd), 64'(exp_wb_rd));
        chk("wb_data", wb_data, exp_wb_data);
        chk("wb_mis",  64'(wb_misalign), 64'(exp_wb_mis));
      end
    end
  end

  // One transaction: accept, serve request/response with optional stalls,
  // optionally spray stray responses outside WAIT, then drain writeback.
  task automatic run(input string tag, input logic [1:0] op, input logic [1:0] size, input logic sgn,
                     input logic [63:0] res, input logic [63:0] wdat, input logic [63:0] rdata,
                     input logic [4:0] rd, input int rq_stall, input int wb_stall, input bit spur);
    logic mem, mis, wen;
    logic [63:0] data;
    int nb, off, k, rs, ws;
    bit due, fin, hs_req, hs_wb, seen;
    model(op, size, sgn, res, rdata, rd, mem, mis, wen, data);
    nb  = 1 << size;
    off = int'(res[2:0]);
    exp_req_on  = mem;
    exp_addr    = res & ~64'h7;
    exp_wmask   = 8'(((16'd1 << nb) - 16'd1) << off);
    exp_wdata   = wdat << (8 * off);
    exp_wen     = (op == 2'b10);
    exp_wb_wen  = wen;
    exp_wb_rd   = rd;
    exp_wb_data = data;
    exp_wb_mis  = mis;
    exp_active  = 1'b1;
    chk({tag, "_ready_idle"}, 64'(ex_ready), 64'd1);
    ex_valid = 1'b1; ex_mem_op = op; ex_size = size; ex_signed = sgn;
    ex_result = res; ex_wdata = wdat; ex_rd = rd;
    @(posedge clk); #1;
    // Scramble inputs after accept to prove they were captured.
    ex_valid = 1'b0; ex_mem_op = ~op; ex_size = ~size; ex_signed = ~sgn;
    ex_result = ~res; ex_wdata = ~wdat; ex_rd = ~rd;
    k = 1; rs = rq_stall; ws = wb_stall; due = 0; fin = 0; seen = 0;
    obs_lat = 0; obs_reqs = 0;
    while (!fin && k < 64) begin
      chk({tag, "_ex_ready_busy"}, 64'(ex_ready), 64'd0);
      mem_req_ready = (rs == 0);
      if (mem_req_valid && rs > 0) rs--;
      hs_req = mem_req_valid && mem_req_ready;
      if (mem_req_valid) begin
        obs_addr = mem_req_addr; obs_wdata = mem_req_wdata;
        obs_wmask = mem_req_wmask; obs_req_wen = mem_req_wen;
      end
      mem_rsp_valid = due || spur;
      mem_rsp_rdata = due ? rdata : ~rdata;
      due = 0;
      if (wb_valid && !seen) begin
        seen = 1; obs_lat = k;
        obs_wb_data = wb_data; obs_wb_wen = wb_wen; obs_mis = wb_misalign;
      end
      wb_ready = wb_valid && (ws == 0);
      if (wb_valid && ws > 0) ws--;
      hs_wb = wb_valid && wb_ready;
      @(posedge clk); #1;
      if (hs_req) begin due = 1; obs_reqs++; end
      if (hs_wb) fin = 1;
      k++;
    end
    mem_req_ready = 0; mem_rsp_valid = 0; wb_ready = 0;
    chk({tag, "_finished"}, 64'(fin), 64'd1);
    chk({tag, "_latency"}, 64'(obs_lat), mem ? 64'(3 + rq_stall) : 64'd1);
    chk({tag, "_req_count"}, 64'(obs_reqs), 64'(mem));
    chk({tag, "_ready_after"}, 64'(ex_ready), 64'd1);
    exp_active = 1'b0;
  endtask

  initial begin
    // Reset state.
    #12;
    chk("rst_ex_ready", 64'(ex_ready), 64'd1);
    chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_data", wb_data, 64'd0);
    chk("rst_req_addr", mem_req_addr, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Pass-through.
    run("pass", 2'b00, 2'b11, 1'b0, 64'h1234, 64'h0, 64'h0, 5'd5, 0, 0, 0);
    chk("pass_lit_data", obs_wb_data, 64'h1234);
    chk("pass_lit_wen", 64'(obs_wb_wen), 64'd1);

    // Reserved op on an odd address: plain pass-through, no misalign.
    run("resv", 2'b11, 2'b01, 1'b0, 64'h8000_0003, 64'h0, 64'h0, 5'd0, 0, 0, 0);
    chk("resv_lit_mis", 64'(obs_mis), 64'd0);

    // Byte loads. Byte 3 of 0x80FF0000 is 0x80; byte 2 is 0xFF.
    run("lb3s", 2'b01, 2'b00, 1'b1, 64'h8000_0003, 64'h0, 64'h0000_0000_80FF_0000, 5'd10, 0, 0, 0);
    chk("lb3s_lit_addr", obs_addr, 64'h8000_0000);
    chk("lb3s_lit_data", obs_wb_data, 64'hFFFF_FFFF_FFFF_FF80);
    run("lb2s", 2'b01, 2'b00, 1'b1, 64'h8000_0002, 64'h0, 64'h0000_0000_80FF_0000, 5'd10, 0, 0, 0);
    chk("lb2s_lit_data", obs_wb_data, 64'hFFFF_FFFF_FFFF_FFFF);
    run("lb2u", 2'b01, 2'b00, 1'b0, 64'h8000_0002, 64'h0, 64'h0000_0000_80FF_0000, 5'd10, 0, 0, 0);
    chk("lb2u_lit_data", obs_wb_data, 64'h0000_0000_0000_00FF);

    // Word store in the upper half.
    run("sw", 2'b10, 2'b10, 1'b0, 64'h8000_0004, 64'hDEAD_BEEF, 64'h0, 5'd7, 0, 0, 0);
    chk("sw_lit_wmask", 64'(obs_wmask), 64'h0F0);
    chk("sw_lit_wdata_hi", 64'(obs_wdata[63:32]), 64'hDEAD_BEEF);
    chk("sw_lit_req_wen", 64'(obs_req_wen), 64'd1);
    chk("sw_lit_wb_wen", 64'(obs_wb_wen), 64'd0);

    // Misaligned accesses: no request, latency 1.
    run("lh_mis", 2'b01, 2'b01, 1'b0, 64'h8000_0001, 64'h0, 64'h0, 5'd3, 0, 0, 0);
    chk("lh_mis_lit_flag", 64'(obs_mis), 64'd1);
    chk("lh_mis_lit_data", obs_wb_data, 64'h8000_0001);
    run("sd_mis", 2'b10, 2'b11, 1'b0, 64'h8000_000C, 64'h55, 64'h0, 5'd3, 0, 0, 0);
    run("lw_mis", 2'b01, 2'b10, 1'b1, 64'h8000_0006, 64'h0, 64'h0, 5'd3, 0, 0, 0);

    // Double load to x0, signed half at the top lane, half store at lane 6.
    run("ld_x0", 2'b01, 2'b11, 1'b1, 64'h8000_0010, 64'h0, 64'h0123_4567_89AB_CDEF, 5'd0, 0, 0, 0);
    run("lh6s", 2'b01, 2'b01, 1'b1, 64'h8000_0016, 64'h0, 64'h8001_0000_0000_0000, 5'd9, 0, 0, 0);
    chk("lh6s_lit_data", obs_wb_data, 64'hFFFF_FFFF_FFFF_8001);
    run("sh6", 2'b10, 2'b01, 1'b0, 64'h8000_0026, 64'hBEEF, 64'h0, 5'd1, 1, 1, 1);
    chk("sh6_lit_wmask", 64'(obs_wmask), 64'h0C0);

    // Backpressure on both sides with stray responses outside WAIT.
    run("bp_lw", 2'b01, 2'b10, 1'b1, 64'h8000_0104, 64'h0, 64'h8000_0001_1111_2222, 5'd31, 3, 2, 1);
    chk("bp_lw_lit_data", obs_wb_data, 64'hFFFF_FFFF_8000_0001);

    // Reset while waiting for the response.
    ex_valid = 1'b1; ex_mem_op = 2'b01; ex_size = 2'b11; ex_signed = 1'b0;
    ex_result = 64'h8000_0040; ex_rd = 5'd4;
    @(posedge clk); #1;
    ex_valid = 1'b0; mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    chk("rmid_in_wait", 64'(mem_req_valid), 64'd0);
    rst_n = 1'b0; #1;
    chk("rmid_ex_ready", 64'(ex_ready), 64'd1);
    chk("rmid_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rmid_req_addr", mem_req_addr, 64'd0);
    chk("rmid_req_wen", 64'(mem_req_wen), 64'd0);
    chk("rmid_req_wmask", 64'(mem_req_wmask), 64'd0);
    chk("rmid_req_wdata", mem_req_wdata, 64'd0);
    chk("rmid_wb_valid", 64'(wb_valid), 64'd0);
    chk("rmid_wb_out", {wb_data[58:0], wb_rd}, 64'd0);
    chk("rmid_wb_flags", {62'd0, wb_wen, wb_misalign}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'hAAAA_5555_AAAA_5555;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rmid_no_wb", 64'(wb_valid), 64'd0);
      chk("rmid_idle", 64'(ex_ready), 64'd1);
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
